// File: rtl/t02_ram_responder_if.sv
// Request/response bundle between a core's RAM port and the RAM responder.
// The master drives the request; the slave returns data, busy and error status.
interface t02_ram_responder_if;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    modport master (
        output Ren, Wen, ramaddr, ramstore,
        input  ramload, busy_o, err_o
    );

    modport slave (
        input  Ren, Wen, ramaddr, ramstore,
        output ramload, busy_o, err_o
    );
endinterface

// File: rtl/t02_ram_responder.sv
// Word-array RAM responder: accepts one read or write at a time, holds busy_o for
// a fixed latency, then presents the result for exactly one DONE cycle.
module t02_ram_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] OOR_DATA  = 32'hBAD0_BAD0
) (
    input  logic              CLK,
    input  logic              RST,
    t02_ram_responder_if.slave bus
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               op_wr_q,    op_wr_d;
    logic               conflict_q, conflict_d;
    logic               in_range_q, in_range_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [31:0]        wdata_q,    wdata_d;
    logic [31:0]        ramload_q,  ramload_d;
    logic               err_q,      err_d;

    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        offset_s;
    logic               addr_ok_s;
    logic               req_s;
    logic               busy_s;
    logic               mem_we_s;

    // Address decode of the live request; only sampled when an access is accepted.
    always_comb begin
        offset_s  = bus.ramaddr - BASE_ADDR;
        addr_ok_s = (bus.ramaddr >= BASE_ADDR) && ({2'b00, offset_s[31:2]} < DEPTH_W);
        req_s     = bus.Ren | bus.Wen;
    end

    // Next-state, access strobes and combinational busy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        conflict_d = conflict_q;
        in_range_d = in_range_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        ramload_d  = ramload_q;
        err_d      = 1'b0;
        busy_s     = 1'b0;
        mem_we_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    busy_s     = 1'b1;
                    state_d    = S_BUSY;
                    op_wr_d    = bus.Wen;
                    conflict_d = bus.Ren & bus.Wen;
                    in_range_d = addr_ok_s;
                    idx_d      = offset_s[IDX_W+1:2];
                    wdata_d    = bus.ramstore;
                    cnt_d      = CNT_W'(LATENCY - 1);
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_BUSY: begin
                busy_s = 1'b1;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_DONE;
                    err_d   = ~in_range_q | conflict_q;
                    if (op_wr_q) begin
                        mem_we_s = in_range_q;
                    end else begin
                        ramload_d = in_range_q ? mem_q[idx_q] : OOR_DATA;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_wr_q    <= 1'b0;
            conflict_q <= 1'b0;
            in_range_q <= 1'b0;
            idx_q      <= {IDX_W{1'b0}};
            wdata_q    <= 32'h0000_0000;
            ramload_q  <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            conflict_q <= conflict_d;
            in_range_q <= in_range_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            ramload_q  <= ramload_d;
            err_q      <= err_d;
        end
    end

    // Array is never cleared; a reset landing on the write edge cancels the write.
    always_ff @(posedge CLK) begin
        if (mem_we_s && !RST) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.ramload = ramload_q;
    assign bus.err_o   = err_q;
    assign bus.busy_o  = busy_s;

endmodule

// File: doc/t02_ram_responder.md
Name: t02_ram_responder

Overview:
- Memory-side responder to the core's RAM request port (Ren/Wen/ramaddr/ramstore in; ramload/busy_o out).
- Services one word read or write at a time from an internal word array, with a parameterised access latency.
- Signals that latency to the requester through busy_o.
- Serves as the on-chip RAM model for core integration and as the bench target for the memory request path.

Parameters:
- DEPTH, 1024, number of 32-bit words in the internal array (power of two, >= 4)
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0
- LATENCY, 2, cycles busy_o stays high after acceptance (>= 1)
- OOR_DATA, 32'hBAD0_BAD0, read data returned for an out-of-range address

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- Ren  in  1  read request, held by requester until busy_o falls
- Wen  in  1  write request, held by requester until busy_o falls
- ramaddr  in  32  byte address; bits [1:0] ignored
- ramstore  in  32  write data
- ramload  out  32  read data; valid in the DONE cycle
- busy_o  out  1  responder busy; requester must not consume ramload while high
- err_o  out  1  one-cycle pulse in DONE for out-of-range access or Ren&Wen conflict

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous and active-high (RST); polarity and synchronicity are fixed.
- States: IDLE, BUSY, DONE.
- Reset (synchronous, RST high at the edge):
  - state=IDLE, counter=0, ramload=0, err_o=0, latched request cleared.
  - busy_o is then 0 unless Ren|Wen is high.
  - Array contents are not cleared.
  - Reset mid-BUSY abandons the access: a pending write is not performed.
- Index computation: idx = (ramaddr - BASE_ADDR) >> 2, 32-bit unsigned.
  - In range iff ramaddr >= BASE_ADDR and idx < DEPTH.
- IDLE:
  - If Ren|Wen: accept. Latch op, idx, in-range flag and ramstore. Load counter = LATENCY-1. Next state BUSY.
  - Op priority: Wen over Ren. If both are high, perform the write and set the conflict flag.
- busy_o = (state==IDLE & (Ren|Wen)) | (state==BUSY), combinational.
  - busy_o is high in the acceptance cycle, so the requester never sees a false "done".
- BUSY:
  - If counter==0: perform the access and go to DONE.
    - Write: array[idx] <= latched data, only if in range.
    - Read: ramload <= array[idx] if in range, else OOR_DATA.
  - Else decrement the counter.
  - Changes on Ren/Wen/ramaddr/ramstore during BUSY are ignored.
- DONE (exactly one cycle):
  - busy_o=0, ramload valid.
  - err_o=1 if the access was out of range or a conflict, else 0.
  - Next state IDLE.
- Timing: total access = LATENCY+1 cycles from the acceptance edge to the DONE cycle.
  - LATENCY=1: accept at edge k, BUSY during k..k+1, DONE cycle after edge k+1.
- ramload holds its last value outside DONE. Writes do not update ramload.
- Back-to-back:
  - A request still held in the IDLE cycle after DONE is accepted as a new access.
  - The requester must change or drop its request in the DONE cycle if it is finished.
- Throughput: one access per LATENCY+2 cycles.
- Read-after-write to the same address in consecutive accesses returns the new data.

Test Plan:
- Reset, then Ren=1, ramaddr=0x10 after the array is preloaded with word4=0xCAFEF00D, LATENCY=2 -> busy_o high 3 cycles from the request; DONE cycle shows ramload=0xCAFEF00D, err_o=0.
- Wen=1, ramaddr=0x20, ramstore=0x12345678, then Ren at 0x20 -> read returns 0x12345678; ramload unchanged during the write access.
- Ren at BASE_ADDR+4*DEPTH -> ramload=0xBAD0BAD0, err_o pulses 1 cycle. Wen at the same address -> array unchanged, err_o pulses.
- Ren=Wen=1, ramaddr=0x8, ramstore=0xA5A5A5A5 -> write performed, err_o=1. Subsequent read of 0x8 returns 0xA5A5A5A5 with err_o=0.
- Write to 0x30 with RST asserted in the 2nd BUSY cycle -> state IDLE, busy_o=0 after the edge; read of 0x30 returns the pre-write value.
- Ren held continuously on 0x0/0x4 alternating in DONE cycles, LATENCY=1 -> accesses every 3 cycles, busy_o low exactly one cycle each, correct data each time.
